// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit.
// Shift-add multiply and restoring divide, one bit per cycle, with
// sign handling done once on operand magnitudes at accept and once on
// the final value when the result is registered.
module mul_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     operand_q, operand_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN:0]       rem_q, rem_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                signed1, signed2;
  logic                neg1, neg2;
  logic [XLEN-1:0]     mag1, mag2;
  logic                acceptNeg;
  logic                divByZero, divOverflow;

  logic [XLEN:0]       mulSum;
  logic [2*XLEN-1:0]   mulNext;
  logic [2*XLEN-1:0]   prodSigned;
  logic [XLEN-1:0]     mulResult;

  logic [XLEN+1:0]     divShift;
  logic [XLEN+1:0]     divTrial;
  logic                divGe;
  logic [XLEN:0]       remNext;
  logic [XLEN-1:0]     quoNext;
  logic [XLEN-1:0]     divRaw;
  logic [XLEN-1:0]     divResult;
  logic [XLEN-1:0]     finalResult;

  // Accept-time operand decode: magnitudes, result sign, divide special cases.
  always_comb begin
    signed1     = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    signed2     = op[2] ? ~op[0] : ~op[1];
    neg1        = signed1 & src1[XLEN-1];
    neg2        = signed2 & src2[XLEN-1];
    mag1        = neg1 ? -src1 : src1;
    mag2        = neg2 ? -src2 : src2;
    acceptNeg   = (op == 3'd6) ? neg1 : (neg1 ^ neg2);
    divByZero   = op[2] && (src2 == '0);
    divOverflow = op[2] && !op[0] &&
                  (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);
  end

  // One iteration of each algorithm plus the sign-corrected final result.
  always_comb begin
    mulSum      = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                  (acc_q[0] ? {1'b0, operand_q} : '0);
    mulNext     = {mulSum, acc_q[XLEN-1:1]};
    prodSigned  = neg_q ? -mulNext : mulNext;
    mulResult   = (op_q[1:0] == 2'b00) ? prodSigned[XLEN-1:0]
                                       : prodSigned[2*XLEN-1:XLEN];

    divShift    = {rem_q, acc_q[XLEN-1]};
    divTrial    = divShift - {2'b00, operand_q};
    divGe       = ~divTrial[XLEN+1];
    remNext     = divGe ? divTrial[XLEN:0] : divShift[XLEN:0];
    quoNext     = {acc_q[XLEN-2:0], divGe};
    divRaw      = op_q[1] ? remNext[XLEN-1:0] : quoNext;
    divResult   = neg_q ? -divRaw : divRaw;

    finalResult = op_q[2] ? divResult : mulResult;
  end

  // State register and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      operand_q <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      operand_q <= operand_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      result_q  <= result_d;
    end
  end

  // Next-state and register update logic; flush beats start and iteration.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    op_d      = op_q;
    neg_d     = neg_q;
    operand_d = operand_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    result_d  = result_q;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d    = op;
          neg_d   = acceptNeg;
          count_d = CNT_W'(XLEN);
          rem_d   = '0;
          if (op[2]) begin
            acc_d     = {{XLEN{1'b0}}, mag1};
            operand_d = mag2;
            if (divByZero) begin
              state_d  = DONE;
              result_d = op[1] ? src1 : '1;
            end else if (divOverflow) begin
              state_d  = DONE;
              result_d = op[1] ? '0 : src1;
            end else begin
              state_d  = DIV;
            end
          end else begin
            acc_d     = {{XLEN{1'b0}}, mag2};
            operand_d = mag1;
            state_d   = MUL;
          end
        end
      end
      MUL: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d   = mulNext;
          count_d = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            state_d  = DONE;
            result_d = finalResult;
          end
        end
      end
      DIV: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d   = {acc_q[2*XLEN-1:XLEN], quoNext};
          rem_d   = remNext;
          count_d = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            state_d  = DONE;
            result_d = finalResult;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the current state and the result register.
  always_comb begin
    busy   = (state_q != IDLE);
    done   = (state_q == DONE);
    result = result_q;
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          checkCount = 0;
  int          errorCount = 0;
  logic [31:0] lastResult;

  mul_div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .flush  (flush),
    .op     (op),
    .src1   (src1),
    .src2   (src2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Count one comparison and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issue one operation from IDLE, scramble the inputs after accept, wait
  // for done and check latency, busy length, result and return to IDLE.
  // pokeAt > 0 pulses start for one cycle that many cycles after accept.
  task automatic applyStimulus(input string tag, input logic [2:0] opIn,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expResult, input int expLatency,
                               input int pokeAt);
    int cycles;
    int busyCycles;
    @(negedge clk);
    start = 1'b1;
    op    = opIn;
    src1  = a;
    src2  = b;
    @(negedge clk);
    start      = 1'b0;
    op         = 3'd5;
    src1       = 32'hDEAD_BEEF;
    src2       = 32'h0000_0000;
    cycles     = 1;
    busyCycles = 0;
    while (!done && cycles < 100) begin
      if (busy) busyCycles++;
      start = (cycles == pokeAt);
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    if (busy) busyCycles++;
    checkOutput({tag, "_done"}, {31'b0, done}, 32'd1);
    checkOutput({tag, "_latency"}, cycles, expLatency);
    checkOutput({tag, "_busy"}, busyCycles, expLatency);
    checkOutput({tag, "_result"}, result, expResult);
    @(negedge clk);
    checkOutput({tag, "_idle"}, {30'b0, busy, done}, 32'd0);
    checkOutput({tag, "_hold"}, result, expResult);
    lastResult = expResult;
  endtask

  initial begin
    int doneSeen;
    int cyc;
    int k;
    int prevDone;
    logic [2:0]  vecOp  [3];
    logic [31:0] vecA   [3];
    logic [31:0] vecB   [3];
    logic [31:0] vecExp [3];

    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = 3'd0;
    src1  = 32'h0;
    src2  = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    rst = 1'b0;

    $display("[TB] multiply");
    applyStimulus("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
    applyStimulus("mulh_m1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 0);
    applyStimulus("mulhu_m1", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
    applyStimulus("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0);
    applyStimulus("mul_lo", 3'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33, 0);

    $display("[TB] divide");
    applyStimulus("div_-7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
    applyStimulus("rem_-7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
    applyStimulus("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 33, 0);
    applyStimulus("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, 33, 0);

    $display("[TB] divide special cases");
    applyStimulus("divu_by0", 3'd5, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1, 0);
    applyStimulus("rem_by0", 3'd6, 32'h0000_1234, 32'd0, 32'h0000_1234, 1, 0);
    applyStimulus("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    applyStimulus("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);

    $display("[TB] start while busy");
    applyStimulus("mul_poke", 3'd0, 32'd3, 32'd5, 32'd15, 33, 5);

    $display("[TB] flush mid divide");
    @(negedge clk);
    start = 1'b1;
    op    = 3'd5;
    src1  = 32'd1000;
    src2  = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput("flush_pre_busy", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_busy", {31'b0, busy}, 32'd0);
    doneSeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("flush_no_done", doneSeen, 32'd0);
    checkOutput("flush_result", result, lastResult);

    $display("[TB] flush with start in idle");
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    op    = 3'd5;
    src1  = 32'd5;
    src2  = 32'd0;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    checkOutput("idle_flush_busy", {31'b0, busy}, 32'd0);
    checkOutput("idle_flush_done", {31'b0, done}, 32'd0);
    checkOutput("idle_flush_result", result, lastResult);

    $display("[TB] reset mid multiply");
    @(negedge clk);
    start = 1'b1;
    op    = 3'd0;
    src1  = 32'd3;
    src2  = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_mid_done", {31'b0, done}, 32'd0);
    checkOutput("rst_mid_result", result, 32'd0);
    rst = 1'b0;
    lastResult = 32'd0;

    $display("[TB] back-to-back with start held");
    vecOp[0] = 3'd0; vecA[0] = 32'd6;         vecB[0] = 32'd7;         vecExp[0] = 32'd42;
    vecOp[1] = 3'd7; vecA[1] = 32'd100;       vecB[1] = 32'd7;         vecExp[1] = 32'd2;
    vecOp[2] = 3'd3; vecA[2] = 32'hFFFF_FFFF; vecB[2] = 32'hFFFF_FFFF; vecExp[2] = 32'hFFFF_FFFE;
    @(negedge clk);
    start    = 1'b1;
    op       = vecOp[0];
    src1     = vecA[0];
    src2     = vecB[0];
    k        = 0;
    prevDone = -1;
    cyc      = 0;
    while (k < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        checkOutput($sformatf("b2b_result%0d", k), result, vecExp[k]);
        if (k > 0) checkOutput($sformatf("b2b_period%0d", k), cyc - prevDone, 32'd34);
        prevDone = cyc;
        k++;
        if (k < 3) begin
          op   = vecOp[k];
          src1 = vecA[k];
          src2 = vecB[k];
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    checkOutput("b2b_count", k, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
